// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file peripheral.
//   spi_state_t : frame FSM states (IDLE, CMD, DATA, DONE)
//   RW_WRITE / RW_READ : encoding of the first bit of a frame
//   frame_len() : total bits in a frame (R/W + address + data)
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI bus bundle between a controller and the register-file peripheral.
//   ncs  : chip select, active-low (controller -> peripheral)
//   sclk : SPI clock, mode 0 (controller -> peripheral)
//   copi : controller-out data (controller -> peripheral)
//   cipo : controller-in data (peripheral -> controller)
interface spi_regfile_peripheral_if;

    logic ncs;
    logic sclk;
    logic copi;
    logic cipo;

    modport master (output ncs, output sclk, output copi, input cipo);
    modport slave  (input ncs, input sclk, input copi, output cipo);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with edge detection.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   level      : synchronised level
//   rise, fall : one-clk pulses on synchronised rising / falling edges
// RESET_VAL sets the reset value of all flops (1 for an idle-high input).
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[0], d};
            prev_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~prev_q;
    assign fall  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI (mode 0) slave giving write access to a small register file.
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, MSB first.
// A write commits when chip select rises after exactly FRAME_LEN bits.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi        : SPI bus (slave modport: ncs, sclk, copi in; cipo out)
//   regs_flat  : register i at bits [i*DATA_W +: DATA_W]
//   wr_strobe  : one-clk pulse per committed write
//   wr_addr    : address of the last committed write
//   frame_err  : one-clk pulse per malformed (short/overlong) frame
// Optional feature macro: SPI_READBACK_EN enables register read-back on cipo
// for R/W = 0 frames; without it cipo is tied low.
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_regfile_peripheral_if.slave      spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CMD_LEN   = 1 + ADDR_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    logic ncs_level, ncs_rise, ncs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(spi.ncs),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi.sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(spi.copi),
        .level(copi_level), .rise(copi_rise), .fall(copi_fall)
    );

    spi_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_LEN-1:0] shift_q;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [1:0]           settle_q;
    logic                 armed_q;

    logic                 start;
    logic                 sample;
    logic                 frame_rw;
    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;
    logic                 addr_ok;
    logic                 len_ok;
    logic                 commit;
    logic                 err;

    // The ncs synchroniser resets high, so if the pin is already low when
    // reset releases it produces a falling edge that is not a real frame
    // start. Arming only after a genuinely high ncs has been seen (once the
    // synchroniser has flushed) discards any frame caught by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && ncs_level) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign start  = (state_q == IDLE) && ncs_fall && armed_q;
    assign sample = sclk_rise && !ncs_level && (state_q != IDLE);

    assign frame_rw   = shift_q[FRAME_LEN-1];
    assign frame_addr = shift_q[FRAME_LEN-2 -: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];
    assign addr_ok    = {1'b0, frame_addr} < (ADDR_W+1)'(NUM_REGS);
    assign len_ok     = (cnt_q == CNT_W'(FRAME_LEN));
    assign commit     = ncs_rise && len_ok && (frame_rw == RW_WRITE) && addr_ok;
    // An empty select (no sclk edges) is neither a write nor an error.
    assign err        = ncs_rise && !len_ok && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CMD;
            CMD:  if (sample && cnt_q == CNT_W'(CMD_LEN - 1)) state_d = DATA;
            DATA: if (sample && cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (ncs_rise) begin
            state_d = IDLE;
        end
    end

    // Bit counter saturates one past a full frame so overlong frames stay
    // distinguishable from correct ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (sample) begin
            shift_q <= {shift_q[FRAME_LEN-2:0], copi_level};
            if (cnt_q != CNT_W'(FRAME_LEN + 1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= commit;
            frame_err <= err;
            if (commit) begin
                wr_addr <= frame_addr;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && frame_addr == ADDR_W'(i)) begin
                    regs_q[i] <= frame_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rd_word;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rw;

    // While in DATA the low CMD_LEN bits of the shifter hold R/W and address.
    assign rd_rw   = shift_q[ADDR_W];
    assign rd_addr = shift_q[ADDR_W-1:0];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    // The first sclk fall in DATA (count still CMD_LEN) loads the word so
    // its MSB is on cipo before the first data rising edge; later falls shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else if (ncs_rise || state_q == IDLE) begin
            tx_q <= '0;
        end else if (state_q == DATA && sclk_fall && !ncs_level) begin
            if (cnt_q == CNT_W'(CMD_LEN)) begin
                tx_q <= (rd_rw == RW_READ) ? rd_word : '0;
            end else begin
                tx_q <= {tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign spi.cipo = !ncs_level && tx_q[DATA_W-1];

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_level, copi_rise, copi_fall};
`else
    assign spi.cipo = 1'b0;

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_level, sclk_fall, copi_rise, copi_fall};
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench for spi_regfile_peripheral (default parameters).
// Frames are driven from a vector table plus hand-written sequences for
// mid-frame reset and read-back; expectations go to a scoreboard queue and
// are compared once each frame has been committed.
// Define SPI_READBACK_EN for both bench and RTL to exercise read-back.
module tb_spi_regfile_peripheral;
    import spi_pkg::*;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 5;
    localparam int HALF     = 4;
    localparam int RW       = NUM_REGS * DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_regfile_peripheral_if spi ();

    logic [RW-1:0]     regs_flat;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_err;

    spi_regfile_peripheral #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi(spi.slave),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .frame_err(frame_err)
    );

    typedef struct {
        string       name;
        int          nbits;
        logic [31:0] bits;
        int          exp_strobe;
        int          exp_err;
    } vec_t;

    typedef struct {
        string             name;
        int                base_strobe;
        int                base_err;
        int                exp_strobe;
        int                exp_err;
        logic [ADDR_W-1:0] exp_addr;
        logic [RW-1:0]     exp_regs;
        logic              chk_rx;
        logic [DATA_W-1:0] exp_rx;
    } exp_t;

    exp_t              sb[$];
    vec_t              vecs[15];
    int                total = 0;
    int                bad = 0;
    int                strobe_cnt = 0;
    int                err_cnt = 0;
    logic [RW-1:0]     strobe_regs = '0;
    logic [RW-1:0]     model_regs = '0;
    logic [ADDR_W-1:0] model_addr = '0;
    logic [DATA_W-1:0] last_rx = '0;

    // Pulse counting and snapshot of the registers in the strobe cycle.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            strobe_regs = regs_flat;
        end
        if (frame_err) begin
            err_cnt++;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spiShift(input logic [31:0] bits, input int hi, input int lo,
                            inout logic [DATA_W-1:0] rx);
        for (int i = hi; i >= lo; i--) begin
            spi.copi = bits[i];
            waitClk(HALF);
            rx = {rx[DATA_W-2:0], spi.cipo};
            spi.sclk = 1'b1;
            waitClk(HALF);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic spiFrame(input int nbits, input logic [31:0] bits,
                            output logic [DATA_W-1:0] rx);
        logic [DATA_W-1:0] r;
        r = '0;
        spi.ncs = 1'b0;
        waitClk(HALF);
        spiShift(bits, nbits - 1, 0, r);
        waitClk(HALF);
        spi.ncs = 1'b1;
        waitClk(3 * HALF);
        rx = r;
    endtask

    task automatic pushExp(input string name, input int exp_strobe, input int exp_err,
                           input logic chk_rx, input logic [DATA_W-1:0] exp_rx);
        exp_t e;
        e.name        = name;
        e.base_strobe = strobe_cnt;
        e.base_err    = err_cnt;
        e.exp_strobe  = exp_strobe;
        e.exp_err     = exp_err;
        e.exp_addr    = model_addr;
        e.exp_regs    = model_regs;
        e.chk_rx      = chk_rx;
        e.exp_rx      = exp_rx;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v, input logic chk_rx, input logic [DATA_W-1:0] exp_rx);
        int a;
        if (v.exp_strobe != 0) begin
            a = int'(v.bits[14:8]);
            model_regs[a*DATA_W +: DATA_W] = v.bits[7:0];
            model_addr = v.bits[14:8];
        end
        pushExp(v.name, v.exp_strobe, v.exp_err, chk_rx, exp_rx);
        spiFrame(v.nbits, v.bits, last_rx);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        compare({e.name, " strobes"}, 64'(strobe_cnt - e.base_strobe), 64'(e.exp_strobe));
        if (e.exp_err >= 0) begin
            compare({e.name, " errors"}, 64'(err_cnt - e.base_err), 64'(e.exp_err));
        end
        compare({e.name, " wr_addr"}, 64'(wr_addr), 64'(e.exp_addr));
        compare({e.name, " regs"}, 64'(regs_flat), 64'(e.exp_regs));
        if (e.exp_strobe != 0) begin
            compare({e.name, " regs@strobe"}, 64'(strobe_regs), 64'(e.exp_regs));
        end
        compare({e.name, " cipo idle"}, 64'(spi.cipo), 64'(0));
        if (e.chk_rx) begin
            compare({e.name, " readback"}, 64'(last_rx), 64'(e.exp_rx));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] rx;
        logic [31:0]       part;

        vecs[0]  = '{"wr reg2 A5",     16, 32'h82A5,      1, 0};
        vecs[1]  = '{"cut 10 bits",    10, 32'h81FF >> 6, 0, 1};
        vecs[2]  = '{"17 bit frame",   17, 32'h8377 << 1, 0, 1};
        vecs[3]  = '{"wr addr 7F",     16, 32'hFF11,      0, 0};
        vecs[4]  = '{"wr addr 5",      16, 32'h8522,      0, 0};
        vecs[5]  = '{"empty select",    0, 32'h0,         0, 0};
        vecs[6]  = '{"1 bit frame",     1, 32'h1,         0, 1};
        vecs[7]  = '{"wr reg4 C3",     16, 32'h84C3,      1, 0};
        vecs[8]  = '{"wr reg0 01",     16, 32'h8001,      1, 0};
        vecs[9]  = '{"15 bit frame",   15, 32'h81FF >> 1, 0, 1};
        vecs[10] = '{"20 bit frame",   20, 32'h81FFF,     0, 1};
        vecs[11] = '{"read len ok",    16, 32'h04FF,      0, 0};
        vecs[12] = '{"wr reg1 FF",     16, 32'h81FF,      1, 0};
        vecs[13] = '{"wr reg3 0F",     16, 32'h830F,      1, 0};
        vecs[14] = '{"wr reg2 3C",     16, 32'h823C,      1, 0};

        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        rst_n    = 1'b0;
        waitClk(3);
        compare("reset regs", 64'(regs_flat), 64'(0));
        compare("reset wr_strobe", 64'(wr_strobe), 64'(0));
        compare("reset frame_err", 64'(frame_err), 64'(0));
        compare("reset wr_addr", 64'(wr_addr), 64'(0));
        compare("reset cipo", 64'(spi.cipo), 64'(0));
        rst_n = 1'b1;
        waitClk(2 * HALF);

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], 1'b0, '0);
            checkOutput();
        end

        $display("[TB] reset in the middle of a frame");
        rx = '0;
        part = 32'h81EE;
        spi.ncs = 1'b0;
        waitClk(HALF);
        spiShift(part, 15, 7, rx);
        rst_n = 1'b0;
        waitClk(2);
        compare("midreset regs", 64'(regs_flat), 64'(0));
        compare("midreset wr_addr", 64'(wr_addr), 64'(0));
        compare("midreset cipo", 64'(spi.cipo), 64'(0));
        model_regs = '0;
        model_addr = '0;
        rst_n = 1'b1;
        pushExp("discarded frame", 0, -1, 1'b0, '0);
        spiShift(part, 6, 0, rx);
        waitClk(HALF);
        spi.ncs = 1'b1;
        waitClk(3 * HALF);
        checkOutput();
        applyStimulus('{"wr reg0 3C", 16, 32'h803C, 1, 0}, 1'b0, '0);
        checkOutput();

`ifdef SPI_READBACK_EN
        $display("[TB] read-back");
        applyStimulus('{"wr reg4 5A", 16, 32'h845A, 1, 0}, 1'b0, '0);
        checkOutput();
        applyStimulus('{"rd reg4", 16, 32'h0400, 0, 0}, 1'b1, 8'h5A);
        checkOutput();
        applyStimulus('{"rd reg0", 16, 32'h00FF, 0, 0}, 1'b1, 8'h3C);
        checkOutput();
        applyStimulus('{"rd addr9", 16, 32'h0900, 0, 0}, 1'b1, 8'h00);
        checkOutput();
`else
        $display("[TB] read frames without read-back");
        applyStimulus('{"wr reg4 5A", 16, 32'h845A, 1, 0}, 1'b0, '0);
        checkOutput();
        applyStimulus('{"rd reg4 tied", 16, 32'h0400, 0, 0}, 1'b1, 8'h00);
        checkOutput();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 Parameter ADDR_W, default 7, address field width in bits.
REQ-002 Parameter DATA_W, default 8, data field and register width in bits.
REQ-003 Parameter NUM_REGS, default 5, number of implemented registers; 1 <= NUM_REGS <= 2**ADDR_W.
REQ-004 Port clk  in  1  system clock; all state is clocked on its rising edge.
REQ-005 Port rst_n  in  1  reset: asynchronous, active-low.
REQ-006 Port ncs  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 Port sclk  in  1  SPI clock, mode 0, asynchronous to clk; frequency <= clk/8.
REQ-008 Port copi  in  1  SPI controller-out data.
REQ-009 Port cipo  out  1  SPI controller-in data.
REQ-010 Port regs_flat  out  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
REQ-011 Port wr_strobe  out  1  one-clk pulse on each committed write.
REQ-012 Port wr_addr  out  ADDR_W  address of the last committed write.
REQ-013 Port frame_err  out  1  one-clk pulse on each malformed frame.

Function
REQ-014 ncs, sclk and copi SHALL each pass through a 2-flop synchroniser before use; ncs synchroniser flops reset to 1.
REQ-015 Frame format: 1 R/W bit (1 = write), then ADDR_W address bits, then DATA_W data bits, all MSB first; FRAME_LEN = 1+ADDR_W+DATA_W.
REQ-016 copi SHALL be sampled on the clk cycle in which a rising edge of synchronised sclk is detected, only while synchronised ncs = 0.
REQ-017 FSM states: IDLE, CMD (R/W plus address bits), DATA, DONE.
REQ-018 Transitions: IDLE->CMD on synchronised ncs falling; CMD->DATA after 1+ADDR_W bits; DATA->DONE after DATA_W bits; any state->IDLE on synchronised ncs rising.
REQ-019 Bit counter SHALL saturate at FRAME_LEN+1 and SHALL NOT wrap.
REQ-020 On synchronised ncs rising with count == FRAME_LEN, R/W = 1 and address < NUM_REGS, the addressed register SHALL update on the next clk edge, with wr_strobe = 1 and wr_addr = address in that same cycle.
REQ-021 Write with address >= NUM_REGS: SHALL be silently dropped, with no strobe and no error.
REQ-022 On synchronised ncs rising with count != FRAME_LEN (short or overlong frame): frame_err SHALL pulse 1 clk, no write SHALL occur, and registers SHALL be unchanged.
REQ-023 Synchronised ncs rising with count == 0 (empty select): no action and no error.
REQ-024 Synchronised ncs falling while in DONE is impossible by REQ-018; ncs SHALL be re-armed only from IDLE.
REQ-025 cipo SHALL be 0 whenever synchronised ncs = 1.

Reset
REQ-026 rst_n low SHALL force FSM to IDLE, counter to 0, all registers to 0, wr_addr to 0, and wr_strobe, frame_err and cipo to 0, regardless of frame in progress.
REQ-027 A frame partially shifted when reset releases SHALL be discarded; the next commit requires a fresh ncs falling edge.

Configuration
REQ-028 Macro SPI_READBACK_EN defined: a frame with R/W = 0 and address < NUM_REGS SHALL drive the addressed register on cipo MSB first during DATA, updated on each synchronised sclk falling edge, with the first bit valid before the first DATA rising edge; out-of-range reads SHALL return 0; read frames SHALL never write.
REQ-029 Macro SPI_READBACK_EN undefined: cipo SHALL be tied to 0, and R/W = 0 frames of correct length SHALL be ignored with no error.

Structure
REQ-030 A shared package spi_pkg SHALL hold the FSM state enum, the FRAME_LEN function, and the R/W bit encoding constants.
REQ-031 Synchroniser plus edge detection SHALL be a sub-module spi_sync_edge (2-flop sync, outputs level, rise and fall), instantiated once per input.

Verification
REQ-032 Defaults; write frame 1,0000010,0xA5 -> reg2 = 0xA5, wr_strobe one pulse, wr_addr = 2, other registers 0.
REQ-033 Frame cut after 10 bits -> frame_err one pulse, all registers unchanged.
REQ-034 17-bit frame -> frame_err one pulse, no write.
REQ-035 Write to address 0x7F -> no strobe, no error, registers unchanged.
REQ-036 rst_n asserted mid-frame (bit 9), then a complete write to reg0 = 0x3C -> only reg0 = 0x3C, others 0.
REQ-037 SPI_READBACK_EN defined: write reg4 = 0x5A, then read frame 0,0000100 -> cipo returns 0x5A MSB first; read of address 9 returns 0x00.
